nibble_seq16: RTL and testbench

Nibble-serial operation sequencer: the initiator side of the 4-bit ALU slice interface. It accepts one wide operation (mode, select, carry-in, two operands), drives an external combinational 4-bit slice one nibble per cycle from least to most significant, and chains the slice's carry-out into the next nibble's carry-in. It assembles the wide result, carry-out and zero flag, and signals completion with a one-cycle pulse. It sits between a wide-datapath controller and a single shared slice.

---
 rtl/nibble_seq16.sv | 126 ++++++++++++
 tb/tb_nibble_seq16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_seq16.sv
// nibble_seq16: nibble-serial operation sequencer.
// Accepts one wide operation and drives a shared combinational 4-bit ALU slice
// one nibble per cycle, LSB nibble first. The slice carry-out is chained into
// the carry-in of the next nibble. The block assembles the wide result, the
// final carry and a zero flag, and pulses done for one cycle on completion.
module nibble_seq16 #(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic         mode,
    input  logic [3:0]   sel,
    input  logic         cin,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         alu_m,
    output logic [3:0]   alu_s,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic         alu_ci,
    input  logic [3:0]   alu_o,
    input  logic         alu_co,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         done
);

    localparam int KW = (NIB > 2) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k;
    // Upper operand nibbles still to be presented; nibble 0 goes straight
    // into alu_a/alu_b at accept, so only W-4 bits need to be kept.
    logic [W-5:0]  a_q;
    logic [W-5:0]  b_q;
    logic [W-1:0]  result_next;
    logic          last;
    logic          accept;

    assign ready  = (state == S_IDLE) || (state == S_DONE);
    assign done   = (state == S_DONE);
    assign accept = start && ready;
    assign last   = (k == KW'(NIB - 1));

    // Merge the current slice output into nibble k of the result.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        result_next = result;
        for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
                result_next[4*i +: 4] = alu_o;
            end
        end
    end

    // Sequencer state, registered slice drive and result assembly.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state  <= S_IDLE;
            k      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            alu_m  <= 1'b0;
            alu_s  <= 4'd0;
            alu_a  <= 4'd0;
            alu_b  <= 4'd0;
            alu_ci <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q    <= opa[W-1:4];
                        b_q    <= opb[W-1:4];
                        alu_a  <= opa[3:0];
                        alu_b  <= opb[3:0];
                        alu_m  <= mode;
                        alu_s  <= sel;
                        alu_ci <= cin;
                        k      <= '0;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result <= result_next;
                    k      <= k + 1'b1;
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    if (last) begin
                        // Final nibble: publish flags and park the slice drive.
                        cout   <= alu_co;
                        zero   <= (result_next == '0);
                        alu_a  <= 4'd0;
                        alu_b  <= 4'd0;
                        alu_m  <= 1'b0;
                        alu_s  <= 4'd0;
                        alu_ci <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        // alu_ci doubles as the carry register between nibbles.
                        alu_a  <= a_q[3:0];
                        alu_b  <= b_q[3:0];
                        alu_ci <= alu_co;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_seq16.sv
// Testbench for nibble_seq16 with a behavioural 4-bit adder slice.
module tb_nibble_seq16;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic         mode;
    logic [3:0]   sel;
    logic         cin;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         alu_m;
    logic [3:0]   alu_s;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_ci;
    logic [3:0]   alu_o;
    logic         alu_co;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] slice_sum;
    assign slice_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci};
    assign alu_o     = slice_sum[3:0];
    assign alu_co    = slice_sum[4];

    always #5 clk = ~clk;

    nibble_seq16 #(.NIB(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ready  (ready),
        .mode   (mode),
        .sel    (sel),
        .cin    (cin),
        .opa    (opa),
        .opb    (opb),
        .alu_m  (alu_m),
        .alu_s  (alu_s),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_ci (alu_ci),
        .alu_o  (alu_o),
        .alu_co (alu_co),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .done   (done)
    );

    // Present an operation at a falling edge; the next rising edge accepts it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic m, input logic [3:0] s);
        opa   = a;
        opb   = b;
        cin   = c;
        mode  = m;
        sel   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then compare the published outputs.
    task automatic wait_and_check(input string name, input logic [W-1:0] exp_res,
                                  input logic exp_cout, input logic exp_zero);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s timeout: done never asserted", name);
        else n_pass++;
        n_checks++;
        if (result !== exp_res) $display("FAIL %s result: got %h want %h", name, result, exp_res);
        else n_pass++;
        n_checks++;
        if (cout !== exp_cout) $display("FAIL %s cout: got %b want %b", name, cout, exp_cout);
        else n_pass++;
        n_checks++;
        if (zero !== exp_zero) $display("FAIL %s zero: got %b want %b", name, zero, exp_zero);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 4'd0; cin = 1'b0;
        opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ready, done, zero, cout} !== 4'b1000)
            $display("FAIL reset flags: got rdy/done/zero/cout=%b want 1000", {ready, done, zero, cout});
        else n_pass++;
        n_checks++;
        if (result !== 16'h0000) $display("FAIL reset result: got %h want 0000", result);
        else n_pass++;
        n_checks++;
        if ({alu_m, alu_s, alu_a, alu_b, alu_ci} !== 14'd0)
            $display("FAIL reset alu: got %h want 0", {alu_m, alu_s, alu_a, alu_b, alu_ci});
        else n_pass++;
    endtask

    task automatic test_carry_chain();
        logic [3:0] exp_ci = 4'b0110;   // bit i = expected alu_ci in RUN cycle i
        logic [3:0] exp_a [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
        issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 4'h9);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (alu_ci !== exp_ci[i]) $display("FAIL chain alu_ci[%0d]: got %b want %b", i, alu_ci, exp_ci[i]);
            else n_pass++;
            n_checks++;
            if (alu_a !== exp_a[i] || alu_m !== 1'b1 || alu_s !== 4'h9 || done !== 1'b0 || ready !== 1'b0)
                $display("FAIL chain run[%0d]: a=%h m=%b s=%h done=%b rdy=%b want a=%h m=1 s=9 done=0 rdy=0",
                         i, alu_a, alu_m, alu_s, done, ready, exp_a[i]);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL chain latency: done=%b want 1 in cycle after edge E+4", done);
        else n_pass++;
        wait_and_check("chain", 16'h0100, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b0 || alu_a !== 4'd0) $display("FAIL chain post: done=%b alu_a=%h want 0 0", done, alu_a);
        else n_pass++;
    endtask

    task automatic test_vectors();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h0);
        wait_and_check("wrap", 16'h0000, 1'b1, 1'b1);
        issue(16'h1234, 16'h1111, 1'b1, 1'b0, 4'h0);
        wait_and_check("cin1", 16'h2346, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        opa = 16'h0001; opb = 16'h0001; cin = 1'b0; mode = 1'b0; sel = 4'h0;
        start = 1'b1;
        @(negedge clk);                  // cycle 1 after accept edge E
        opa = 16'h8000; opb = 16'h8000;  // ignored until the DONE cycle
        repeat (3) @(negedge clk);       // cycle 4
        n_checks++;
        if (done !== 1'b0) $display("FAIL b2b early done: got %b want 0", done);
        else n_pass++;
        @(negedge clk);                  // cycle 5: DONE for first op
        n_checks++;
        if (done !== 1'b1 || ready !== 1'b1 || result !== 16'h0002 || cout !== 1'b0)
            $display("FAIL b2b first: done=%b rdy=%b res=%h cout=%b want 1 1 0002 0", done, ready, result, cout);
        else n_pass++;
        @(negedge clk);                  // cycle 6: second op must be running
        start = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h0)
            $display("FAIL b2b second accept: rdy=%b want 0", ready);
        else n_pass++;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 5) $display("FAIL b2b spacing: got %0d cycles want 5", n);
        else n_pass++;
        wait_and_check("b2b second", 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        issue(16'h1111, 16'h2222, 1'b0, 1'b1, 4'h5);
        @(negedge clk);                  // second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0000 ||
            {alu_m, alu_s, alu_a, alu_b, alu_ci} !== 14'd0 || zero !== 1'b0 || cout !== 1'b0)
            $display("FAIL mid reset: rdy=%b done=%b res=%h alu=%h want 1 0 0000 0",
                     ready, done, result, {alu_m, alu_s, alu_a, alu_b, alu_ci});
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== 0) $display("FAIL mid no-done: got %0d pulses want 0", n);
        else n_pass++;
        issue(16'h0005, 16'h0003, 1'b0, 1'b0, 4'h0);
        wait_and_check("after reset", 16'h0008, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_carry_chain();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
